// File: rtl/mux_n1_reg_rr_pkg.sv
// Shared constants for the registered N:1 mux: mode encodings and select-width helper.
package mux_n1_reg_rr_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Bits needed to index n channels, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_n1_reg_rr_arbiter.sv
// Combinational round-robin search: first requesting channel after 'last', wrapping modulo CHANNELS.
module rr_arbiter_n
  import mux_n1_reg_rr_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  int w_k;

  // Walk from the farthest offset down to the nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    w_k     = 0;
    for (int i = CHANNELS; i >= 1; i--) begin
      w_k = (int'(last) + i) % CHANNELS;
      if (req[w_k]) gnt_idx = SEL_W'(w_k);
    end
    gnt_any = |req;
  end

endmodule

// File: rtl/mux_n1_reg_rr.sv
// Registered N:1 mux with valid/ready handshake; channel chosen by selector (direct) or round-robin.
// One output register stage; a word loads whenever the register is empty or being drained.
module mux_n1_reg_rr
  import mux_n1_reg_rr_pkg::*;
#(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      ready_out,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          grant,
  output logic [CHANNELS-1:0]       pop_out
);

  logic [SEL_W-1:0] r_last;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_rr_any;
  logic [SEL_W-1:0] w_c;
  logic             w_cand_ok;
  logic             w_load_en;
  logic             w_fire;
  logic [WIDTH-1:0] w_cand_dat;

  rr_arbiter_n #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req     (valid_in),
    .last    (r_last),
    .gnt_idx (w_rr_idx),
    .gnt_any (w_rr_any)
  );

  // Loop-based indexing keeps out-of-range selectors from ever matching a channel.
  always_comb begin
    w_load_en  = reset_L && (!valid_out || ready_out);
    w_c        = selector;
    w_cand_ok  = 1'b0;
    w_cand_dat = '0;
    pop_out    = '0;
    if (mode == MODE_RR) begin
      w_c       = w_rr_idx;
      w_cand_ok = w_rr_any;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (int'(selector) == k) w_cand_ok = valid_in[k];
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(w_c) == k) w_cand_dat = data_in[k*WIDTH +: WIDTH];
    end
    w_fire = w_load_en && w_cand_ok;
    for (int k = 0; k < CHANNELS; k++) begin
      pop_out[k] = w_fire && (int'(w_c) == k);
    end
  end

  // The RR pointer only advances on round-robin loads; direct loads leave it alone.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      grant     <= '0;
      r_last    <= SEL_W'(CHANNELS - 1);
    end else if (w_load_en) begin
      valid_out <= w_cand_ok;
      if (w_cand_ok) begin
        data_out <= w_cand_dat;
        grant    <= w_c;
        if (mode == MODE_RR) r_last <= w_c;
      end
    end
  end

endmodule

// File: tb/tb_mux_n1_reg_rr.sv
// Directed and random bench for mux_n1_reg_rr against a queue-based behavioural model.
module tb_mux_n1_reg_rr;

  localparam int CH = 4;
  localparam int W  = 2;

  logic            clk;
  logic            reset_L;
  logic            mode;
  logic [1:0]      selector;
  logic [CH-1:0]   valid_in;
  logic [CH*W-1:0] data_in;
  logic            ready_out;
  logic [W-1:0]    data_out;
  logic            valid_out;
  logic [1:0]      grant;
  logic [CH-1:0]   pop_out;

  int checks = 0;
  int errors = 0;

  int   m_valid = 0;
  int   m_data  = 0;
  int   m_grant = 0;
  int   m_last  = CH - 1;
  logic [CH-1:0] last_pop;

  mux_n1_reg_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .mode      (mode),
    .selector  (selector),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant     (grant),
    .pop_out   (pop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check the combinational pop, clock, advance the model, check registers.
  task automatic step(input logic rst, input logic md, input int sel,
                      input logic [CH-1:0] vin, input logic [CH*W-1:0] din, input logic rdy);
    int c;
    bit ok;
    bit load;
    bit found;
    int vq[$];
    logic [CH-1:0] epop;
    reset_L   = rst;
    mode      = md;
    selector  = 2'(sel);
    valid_in  = vin;
    data_in   = din;
    ready_out = rdy;
    #1;
    load  = rst && (m_valid == 0 || rdy);
    ok    = 0;
    c     = 0;
    found = 0;
    if (!md) begin
      c  = sel;
      ok = (sel < CH) && vin[sel];
    end else begin
      for (int k = 0; k < CH; k++) if (vin[k]) vq.push_back(k);
      if (vq.size() > 0) begin
        ok = 1;
        c  = vq[0];
        for (int j = 0; j < vq.size(); j++) begin
          if (!found && vq[j] > m_last) begin
            c     = vq[j];
            found = 1;
          end
        end
      end
    end
    epop = (load && ok) ? CH'(1 << c) : '0;
    last_pop = pop_out;
    chk("pop_out", 32'(pop_out), 32'(epop));
    @(posedge clk);
    #1;
    if (!rst) begin
      m_valid = 0;
      m_data  = 0;
      m_grant = 0;
      m_last  = CH - 1;
    end else if (load) begin
      m_valid = ok ? 1 : 0;
      if (ok) begin
        m_data  = int'(din[c*W +: W]);
        m_grant = c;
        if (md) m_last = c;
      end
    end
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("grant", 32'(grant), 32'(m_grant));
  endtask

  initial begin
    reset_L   = 1'b0;
    mode      = 1'b0;
    selector  = '0;
    valid_in  = '0;
    data_in   = '0;
    ready_out = 1'b0;

    // Reset held two cycles with every channel valid.
    step(0, 0, 0, 4'b1111, 8'hE4, 1);
    step(0, 1, 0, 4'b1111, 8'hE4, 1);
    chk("rst_pop", 32'(last_pop), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);

    // Direct load of channel 2.
    step(1, 0, 2, 4'b0100, 8'b00_10_00_00, 1);
    chk("dir_pop", 32'(last_pop), 32'h4);
    chk("dir_data", 32'(data_out), 32'h2);
    chk("dir_valid", 32'(valid_out), 32'h1);
    chk("dir_grant", 32'(grant), 32'h2);

    // Stall: inputs churn, output must hold.
    step(1, 0, 0, 4'b1011, 8'h5A, 0);
    chk("stall_pop0", 32'(last_pop), 32'h0);
    step(1, 1, 1, 4'b0000, 8'hFF, 0);
    chk("stall_pop1", 32'(last_pop), 32'h0);
    step(1, 0, 3, 4'b1111, 8'h33, 0);
    chk("stall_pop2", 32'(last_pop), 32'h0);
    chk("stall_data", 32'(data_out), 32'h2);
    chk("stall_grant", 32'(grant), 32'h2);
    step(1, 0, 0, 4'b0001, 8'b00_00_00_11, 1);
    chk("unstall_pop", 32'(last_pop), 32'h1);
    chk("unstall_data", 32'(data_out), 32'h3);

    // Round-robin with all valid: pointer still at 3, so 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 4'b1111, 8'b11_10_01_00, 1);
      chk("rr_full_grant", 32'(grant), 32'(i % CH));
      chk("rr_full_data", 32'(data_out), 32'(i % CH));
    end

    // Sparse RR after last=0: 3,0,3.
    step(1, 1, 0, 4'b1001, 8'b01_00_00_10, 1);
    chk("rr_sparse0", 32'(grant), 32'h3);
    step(1, 1, 0, 4'b1001, 8'b01_00_00_10, 1);
    chk("rr_sparse1", 32'(grant), 32'h0);
    step(1, 1, 0, 4'b1001, 8'b01_00_00_10, 1);
    chk("rr_sparse2", 32'(grant), 32'h3);
    step(1, 0, 1, 4'b1101, 8'hAA, 1);
    chk("dir_noload_pop", 32'(last_pop), 32'h0);
    chk("dir_noload_valid", 32'(valid_out), 32'h0);

    // Reset while a word is stalled.
    step(1, 1, 0, 4'b1111, 8'h1B, 1);
    step(0, 1, 0, 4'b1111, 8'h1B, 0);
    chk("midrst_pop", 32'(last_pop), 32'h0);
    chk("midrst_valid", 32'(valid_out), 32'h0);
    step(1, 1, 0, 4'b1111, 8'h1B, 1);
    chk("postrst_pop", 32'(last_pop), 32'h1);
    chk("postrst_grant", 32'(grant), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), 4'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
